alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester/consumer bundle for the shared-ALU arbiter: per-requester operation
// lanes plus the single valid/ready response slot.
interface alu_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [3*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic               rsp_zero;
  logic               rsp_illegal;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between NREQ requesters; the result
// lands in a single-entry response slot drained by valid/ready.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

  // Returns {illegal, result}; undefined encodings yield a recognisable poison value.
  function automatic logic [32:0] alu_calc(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'b000:  return {1'b0, a + b};
      3'b001:  return {1'b0, a - b};
      3'b010:  return {1'b0, a & b};
      3'b011:  return {1'b0, a | b};
      3'b101:  return {1'b0, 31'd0, (a < b)};
      default: return {1'b1, 32'hDEADBEEF};
    endcase
  endfunction

  slot_e          state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]    rsp_result_q, rsp_result_d;
  logic           rsp_zero_q, rsp_zero_d;
  logic           rsp_illegal_q, rsp_illegal_d;

  logic           can_accept_s;
  logic           grant_s;
  logic           found_s;
  logic [IDW-1:0] grant_idx_s;
  logic [IDW:0]   cand_s;
  logic [2:0]     sel_op_s;
  logic [31:0]    sel_a_s;
  logic [31:0]    sel_b_s;
  logic [32:0]    alu_out_s;

  // Round-robin search starting at rr_ptr, wrapping at NREQ (not a power of two).
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s      = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      cand_s      = (cand_s >= (IDW+1)'(NREQ)) ? cand_s - (IDW+1)'(NREQ) : cand_s;
      grant_idx_s = (!found_s && bus.req_valid[cand_s[IDW-1:0]]) ? cand_s[IDW-1:0] : grant_idx_s;
      found_s     = found_s | bus.req_valid[cand_s[IDW-1:0]];
    end
  end

  // Slot output decode: acceptance window and grant qualification.
  always_comb begin
    can_accept_s  = (state_q == SLOT_EMPTY) | bus.rsp_ready;
    grant_s       = can_accept_s & found_s & rst_n;
    bus.req_ready = grant_s ? (NREQ'(1) << grant_idx_s) : '0;
  end

  // Operand mux feeding the shared ALU from the winning lane.
  always_comb begin
    sel_op_s  = bus.req_op[3*int'(grant_idx_s) +: 3];
    sel_a_s   = bus.req_a[32*int'(grant_idx_s) +: 32];
    sel_b_s   = bus.req_b[32*int'(grant_idx_s) +: 32];
    alu_out_s = alu_calc(sel_op_s, sel_a_s, sel_b_s);
  end

  // Slot next state: a grant always fills; a drain without a grant empties.
  always_comb begin
    case (state_q)
      SLOT_EMPTY: state_d = grant_s ? SLOT_FULL : SLOT_EMPTY;
      SLOT_FULL:  state_d = (grant_s || !bus.rsp_ready) ? SLOT_FULL : SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Response payload and pointer update, only on grant edges.
  always_comb begin
    if (grant_s) begin
      rsp_id_d      = grant_idx_s;
      rsp_result_d  = alu_out_s[31:0];
      rsp_zero_d    = (alu_out_s[31:0] == 32'd0);
      rsp_illegal_d = alu_out_s[32];
      rr_ptr_d      = (grant_idx_s == IDW'(NREQ-1)) ? '0 : grant_idx_s + IDW'(1);
    end else begin
      rsp_id_d      = rsp_id_q;
      rsp_result_d  = rsp_result_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_illegal_d = rsp_illegal_q;
      rr_ptr_d      = rr_ptr_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Response payload and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      rsp_id_q      <= '0;
      rsp_result_q  <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign bus.rsp_valid   = (state_q == SLOT_FULL);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters: reset, single op,
// round-robin alternation, backpressure, op coverage and mid-operation reset.
module tb_alu_arbiter;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_arbiter_if #(.NREQ(2), .IDW(1)) bus ();

  alu_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[3*i +: 3]  = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    set_req(0, 3'b000, 32'd1, 32'd1);
    set_req(1, 3'b000, 32'd1, 32'd1);
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %h want 0", bus.rsp_id); end
    checks++; if (bus.rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.rsp_result); end
    checks++; if ({bus.rsp_zero, bus.rsp_illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {bus.rsp_zero, bus.rsp_illegal}); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", bus.req_ready); end
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_req(0, 3'b000, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL single_id: got %h want 0", bus.rsp_id); end
    checks++; if (bus.rsp_result !== 32'd12) begin errors++; $display("FAIL single_result: got %h want 0000000c", bus.rsp_result); end
    checks++; if ({bus.rsp_zero, bus.rsp_illegal} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b want 00", {bus.rsp_zero, bus.rsp_illegal}); end
    tick();
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_ready [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_res   [4] = '{32'd2, 32'd30, 32'd2, 32'd30};
    do_reset();
    set_req(0, 3'b000, 32'd1, 32'd1);
    set_req(1, 3'b000, 32'd10, 32'd20);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.req_ready !== exp_ready[i]) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, bus.req_ready, exp_ready[i]); end
      tick();
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'(i % 2)) begin errors++; $display("FAIL rr_rsp[%0d]: got valid=%b id=%h want valid=1 id=%0d", i, bus.rsp_valid, bus.rsp_id, i % 2); end
      checks++; if (bus.rsp_result !== exp_res[i]) begin errors++; $display("FAIL rr_result[%0d]: got %h want %h", i, bus.rsp_result, exp_res[i]); end
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    set_req(0, 3'b000, 32'd100, 32'd1);
    bus.req_valid = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_ready: got %b want 01", bus.req_ready); end
    tick();
    set_req(1, 3'b011, 32'h0000_000F, 32'h0000_00F0);
    bus.req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b want 00", i, bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd101) begin errors++; $display("FAIL bp_hold_rsp[%0d]: got v=%b id=%h r=%h want v=1 id=0 r=00000065", i, bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_ready: got %b want 10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'h0000_00FF) begin errors++; $display("FAIL bp_next_rsp: got v=%b id=%h r=%h want v=1 id=1 r=000000ff", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
    tick();
  endtask

  task automatic test_ops();
    logic [2:0]  t_op  [7] = '{3'b001, 3'b101, 3'b101, 3'b010, 3'b011, 3'b000, 3'b110};
    logic [31:0] t_a   [7] = '{32'd3, 32'd1, 32'hFFFF_FFFF, 32'h0000_F0F0, 32'h1234_0000, 32'hFFFF_FFFF, 32'd9};
    logic [31:0] t_b   [7] = '{32'd3, 32'hFFFF_FFFF, 32'd1, 32'h0000_FF00, 32'h0000_5678, 32'd1, 32'd9};
    logic [31:0] t_res [7] = '{32'd0, 32'd1, 32'd0, 32'h0000_F000, 32'h1234_5678, 32'd0, 32'hDEAD_BEEF};
    logic [1:0]  t_fl  [7] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01};
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b10;
    for (int i = 0; i < 7; i++) begin
      set_req(1, t_op[i], t_a[i], t_b[i]);
      #1;
      checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL op_ready[%0d]: got %b want 10", i, bus.req_ready); end
      tick();
      checks++; if (bus.rsp_result !== t_res[i] || bus.rsp_id !== 1'b1) begin errors++; $display("FAIL op_result[%0d]: got r=%h id=%h want r=%h id=1", i, bus.rsp_result, bus.rsp_id, t_res[i]); end
      checks++; if ({bus.rsp_zero, bus.rsp_illegal} !== t_fl[i]) begin errors++; $display("FAIL op_flags[%0d]: got zero,illegal=%b want %b", i, {bus.rsp_zero, bus.rsp_illegal}, t_fl[i]); end
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    set_req(0, 3'b000, 32'd2, 32'd2);
    set_req(1, 3'b000, 32'd40, 32'd2);
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b11;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd4) begin errors++; $display("FAIL mid_full: got v=%b r=%h want v=1 r=00000004", bus.rsp_valid, bus.rsp_result); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== 32'd0) begin errors++; $display("FAIL mid_async_clear: got v=%b r=%h want v=0 r=0", bus.rsp_valid, bus.rsp_result); end
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL mid_reset_ready: got %b want 00", bus.req_ready); end
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %b want 01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd4) begin errors++; $display("FAIL mid_after_rsp: got v=%b id=%h r=%h want v=1 id=0 r=00000004", bus.rsp_valid, bus.rsp_id, bus.rsp_result); end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_ops();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
